vreg_wb_queue: RTL and testbench

- Write-back stage directly upstream of the vector register file's write port.
- Accepts results from two producers, the vector ALU and the vector load unit, over valid/ready handshakes.
- Arbitrates round-robin between them, buffers results in a DEPTH-entry FIFO, and drives one register-file write per cycle under write-port backpressure.
- Emits a registered commit pulse per retired write so the scoreboard can clear the destination's pending bit.

---
 rtl/vreg_wb_queue.sv | 128 ++++++++++++
 tb/tb_vreg_wb_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_wb_queue.sv
// Write-back queue in front of the vector register file write port.
// Two producers (vector ALU, vector load unit) are arbitrated round-robin
// into a DEPTH-entry FIFO; the head is presented to the register file and
// each accepted write is followed one cycle later by a commit pulse.
module vreg_wb_queue #(
   parameter int LANES     = 32,
   parameter int ELEM_W    = 16,
   parameter int REG_IDX_W = 5,
   parameter int DEPTH     = 4
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [REG_IDX_W-1:0]       alu_vd,
   input  logic [LANES*ELEM_W-1:0]    alu_data,
   input  logic [LANES-1:0]           alu_mask,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [REG_IDX_W-1:0]       ld_vd,
   input  logic [LANES*ELEM_W-1:0]    ld_data,
   input  logic [LANES-1:0]           ld_mask,
   output logic                       wr_valid,
   input  logic                       wr_ready,
   output logic [REG_IDX_W-1:0]       wr_vd,
   output logic [LANES*ELEM_W-1:0]    wr_data,
   output logic [LANES-1:0]           wr_mask,
   output logic                       done_valid,
   output logic [REG_IDX_W-1:0]       done_vd,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DATA_W = LANES * ELEM_W;

   typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;

   logic [REG_IDX_W-1:0] mem_vd   [DEPTH];
   logic [DATA_W-1:0]    mem_data [DEPTH];
   logic [LANES-1:0]     mem_mask [DEPTH];

   logic [PTR_W-1:0]     head_ptr;
   logic [PTR_W-1:0]     tail_ptr;
   src_e                 rr_last;

   logic                 full;
   logic                 grant_alu;
   logic                 grant_ld;
   logic                 alu_fire;
   logic                 ld_fire;
   logic                 push;
   logic                 pop;
   logic [REG_IDX_W-1:0] in_vd;
   logic [DATA_W-1:0]    in_data;
   logic [LANES-1:0]     in_mask;

   // A source is granted unless the other one is competing and has priority;
   // with no requester both readies sit high, and wr_ready never feeds ready.
   always_comb begin
      full      = (count == CNT_W'(DEPTH));
      grant_alu = !ld_valid  || (alu_valid && rr_last == SRC_LD);
      grant_ld  = !alu_valid || (ld_valid  && rr_last == SRC_ALU);
      alu_ready = !full && grant_alu;
      ld_ready  = !full && grant_ld;
      alu_fire  = alu_valid && alu_ready;
      ld_fire   = ld_valid  && ld_ready;
      push      = alu_fire || ld_fire;
      in_vd     = alu_fire ? alu_vd   : ld_vd;
      in_data   = alu_fire ? alu_data : ld_data;
      in_mask   = alu_fire ? alu_mask : ld_mask;
      wr_valid  = (count != '0);
      wr_vd     = mem_vd[head_ptr];
      wr_data   = mem_data[head_ptr];
      wr_mask   = mem_mask[head_ptr];
      pop       = wr_valid && wr_ready;
   end

   // Entry storage; cleared on reset so the idle head reads as zero.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_vd[i]   <= '0;
            mem_data[i] <= '0;
            mem_mask[i] <= '0;
         end
      end else if (push) begin
         mem_vd[tail_ptr]   <= in_vd;
         mem_data[tail_ptr] <= in_data;
         mem_mask[tail_ptr] <= in_mask;
      end
   end

   // Pointers, occupancy and round-robin history.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         rr_last  <= SRC_LD;
      end else begin
         if (push) begin
            tail_ptr <= tail_ptr + PTR_W'(1);
            rr_last  <= alu_fire ? SRC_ALU : SRC_LD;
         end
         if (pop)
            head_ptr <= head_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Commit pulse one cycle after each accepted register-file write.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         done_valid <= 1'b0;
         done_vd    <= '0;
      end else begin
         done_valid <= pop;
         if (pop)
            done_vd <= wr_vd;
      end
   end

endmodule

// File: tb/tb_vreg_wb_queue.sv
// Bench for vreg_wb_queue: directed scenarios followed by a random phase,
// all checked against a queue-based reference model.
module tb_vreg_wb_queue;

   localparam int LANES  = 32;
   localparam int ELEM_W = 16;
   localparam int RW     = 5;
   localparam int DEPTH  = 4;
   localparam int DW     = LANES * ELEM_W;

   logic            CLK, nRST;
   logic            alu_valid, alu_ready, ld_valid, ld_ready;
   logic [RW-1:0]   alu_vd, ld_vd, wr_vd, done_vd;
   logic [DW-1:0]   alu_data, ld_data, wr_data;
   logic [LANES-1:0] alu_mask, ld_mask, wr_mask;
   logic            wr_valid, wr_ready, done_valid;
   logic [2:0]      count;

   vreg_wb_queue #(.LANES(LANES), .ELEM_W(ELEM_W), .REG_IDX_W(RW), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .nRST(nRST),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_vd(alu_vd),
      .alu_data(alu_data), .alu_mask(alu_mask),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_vd(ld_vd),
      .ld_data(ld_data), .ld_mask(ld_mask),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_vd(wr_vd),
      .wr_data(wr_data), .wr_mask(wr_mask),
      .done_valid(done_valid), .done_vd(done_vd), .count(count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [RW-1:0]    vd;
      logic [DW-1:0]    data;
      logic [LANES-1:0] mask;
   } ent_t;

   ent_t          mq[$];
   bit            m_last_ld;
   bit            m_done;
   logic [RW-1:0] m_done_vd;
   bit            m_alu_fire, m_ld_fire;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
      return d;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_last_ld  = 1'b1;
      m_done     = 1'b0;
      m_done_vd  = '0;
      m_alu_fire = 1'b0;
      m_ld_fire  = 1'b0;
   endtask

   // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
   task automatic cycle();
      bit   full, ar, lr, pop;
      ent_t e;
      @(negedge CLK);
      full = (mq.size() >= DEPTH);
      ar = 1'b1;
      lr = 1'b1;
      if (alu_valid && ld_valid) begin
         ar = m_last_ld;
         lr = !m_last_ld;
      end else if (alu_valid) lr = 1'b0;
      else if (ld_valid) ar = 1'b0;
      ar = ar && !full;
      lr = lr && !full;
      chk("alu_ready", alu_ready, ar);
      chk("ld_ready", ld_ready, lr);
      chk("wr_valid", wr_valid, mq.size() != 0);
      chk("count", count, mq.size());
      if (mq.size() != 0) begin
         chk("wr_vd", wr_vd, mq[0].vd);
         chk("wr_data", wr_data, mq[0].data);
         chk("wr_mask", wr_mask, mq[0].mask);
      end
      chk("done_valid", done_valid, m_done);
      chk("done_vd", done_vd, m_done_vd);
      if (nRST) begin
         pop = (mq.size() != 0) && wr_ready;
         m_done = pop;
         if (pop) begin
            m_done_vd = mq[0].vd;
            void'(mq.pop_front());
         end
         m_alu_fire = alu_valid && ar;
         m_ld_fire  = ld_valid && lr;
         if (m_alu_fire) begin
            e.vd = alu_vd; e.data = alu_data; e.mask = alu_mask;
            mq.push_back(e);
            m_last_ld = 1'b0;
         end else if (m_ld_fire) begin
            e.vd = ld_vd; e.data = ld_data; e.mask = ld_mask;
            mq.push_back(e);
            m_last_ld = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic set_alu(input logic [RW-1:0] vd, input logic [LANES-1:0] mask);
      alu_valid = 1'b1; alu_vd = vd; alu_data = rand_data(); alu_mask = mask;
   endtask

   task automatic set_ld(input logic [RW-1:0] vd, input logic [LANES-1:0] mask);
      ld_valid = 1'b1; ld_vd = vd; ld_data = rand_data(); ld_mask = mask;
   endtask

   // Hold requests until each is accepted, bounded.
   task automatic hold(input int max);
      for (int i = 0; i < max && (alu_valid || ld_valid); i++) begin
         cycle();
         if (m_alu_fire) alu_valid = 1'b0;
         if (m_ld_fire)  ld_valid  = 1'b0;
      end
      chk("hold_timeout", alu_valid || ld_valid, 1'b0);
   endtask

   task automatic drain();
      wr_ready = 1'b1;
      for (int i = 0; i < 20 && mq.size() != 0; i++) cycle();
      cycle();
      chk("drain_count", count, 0);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      model_reset();
      #3;
      nRST = 1'b1;
   endtask

   initial begin
      int v;
      nRST = 1'b0;
      alu_valid = 0; alu_vd = '0; alu_data = '0; alu_mask = '0;
      ld_valid = 0;  ld_vd = '0;  ld_data = '0;  ld_mask = '0;
      wr_ready = 1'b0;
      model_reset();
      #12;
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_wr_vd", wr_vd, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_mask", wr_mask, 0);
      chk("rst_done_valid", done_valid, 0);
      @(posedge CLK); #1;
      nRST = 1'b1;

      // Single ALU write
      wr_ready = 1'b1;
      alu_valid = 1'b1; alu_vd = 5'd3; alu_data = '0; alu_data[15:0] = 16'h3F80; alu_mask = '1;
      cycle();
      alu_valid = 1'b0;
      chk("t1_wr_valid", wr_valid, 1);
      chk("t1_wr_vd", wr_vd, 3);
      cycle();
      chk("t1_done_valid", done_valid, 1);
      chk("t1_done_vd", done_vd, 3);
      chk("t1_count", count, 0);
      cycle();

      // Contention right after reset: ALU first, then LD
      do_reset();
      set_alu(5'd1, '1);
      set_ld(5'd2, '1);
      cycle();
      chk("t2_first_vd", wr_vd, 1);
      if (m_alu_fire) alu_valid = 1'b0;
      if (m_ld_fire)  ld_valid  = 1'b0;
      cycle();
      chk("t2_second_vd", wr_vd, 2);
      hold(4);
      drain();

      // Fill under backpressure, then release
      wr_ready = 1'b0;
      v = 4;
      set_alu(5'd4, '1);
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (m_alu_fire) begin v++; set_alu(RW'(v), '1); end
      end
      chk("t3_full_count", count, 4);
      chk("t3_full_ready", alu_ready, 0);
      chk("t3_stall_vd", wr_vd, 4);
      wr_ready = 1'b1;
      for (int i = 0; i < 10 && v <= 8; i++) begin
         cycle();
         if (m_alu_fire) begin
            v++;
            if (v > 8) alu_valid = 1'b0;
            else set_alu(RW'(v), '1);
         end
      end
      chk("t3_fifth_accepted", v, 9);
      drain();

      // Wrap-around with alternating sources and toggling wr_ready
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) set_alu(RW'(10 + k), LANES'($urandom()));
         else set_ld(RW'(10 + k), LANES'($urandom()));
         for (int i = 0; i < 20 && (alu_valid || ld_valid); i++) begin
            wr_ready = ~wr_ready;
            cycle();
            if (m_alu_fire) alu_valid = 1'b0;
            if (m_ld_fire)  ld_valid  = 1'b0;
         end
         chk("t4_accept_timeout", alu_valid || ld_valid, 0);
      end
      drain();

      // Asynchronous reset with three entries queued
      wr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_alu(RW'(25 + k), '1);
         hold(4);
      end
      chk("t5_pre_count", count, 3);
      #2;
      nRST = 1'b0;
      model_reset();
      #1;
      chk("t5_wr_valid", wr_valid, 0);
      chk("t5_count", count, 0);
      chk("t5_done_valid", done_valid, 0);
      cycle();
      nRST = 1'b1;
      wr_ready = 1'b1;
      set_alu(5'd9, '1);
      hold(4);
      chk("t5_next_vd", wr_vd, 9);
      drain();

      // Zero mask plus simultaneous enqueue/pop at count 2
      wr_ready = 1'b0;
      set_alu(5'd20, '1);
      hold(4);
      set_ld(5'd21, '0);
      hold(4);
      chk("t6_count2", count, 2);
      wr_ready = 1'b1;
      set_alu(5'd22, '1);
      cycle();
      alu_valid = 1'b0;
      chk("t6_count_hold", count, 2);
      chk("t6_zero_mask", wr_mask, 0);
      cycle();
      chk("t6_done_21", done_vd, 21);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if (!alu_valid || m_alu_fire) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_vd = RW'($urandom()); alu_data = rand_data(); alu_mask = LANES'($urandom());
         end
         if (!ld_valid || m_ld_fire) begin
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_vd = RW'($urandom()); ld_data = rand_data(); ld_mask = LANES'($urandom());
         end
         wr_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      if (m_alu_fire) alu_valid = 1'b0;
      if (m_ld_fire)  ld_valid  = 1'b0;
      wr_ready = 1'b1;
      hold(20);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
